// File: rtl/seq_mag_cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Cascade state encoding follows the 4-bit comparator cascade convention {agb,alb,aeb}.
package seq_mag_cmp_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic agb;
    logic alb;
    logic aeb;
  } cas_t;

  localparam cas_t CAS_EQ = '{agb: 1'b0, alb: 1'b0, aeb: 1'b1};
  localparam cas_t CAS_GT = '{agb: 1'b1, alb: 1'b0, aeb: 1'b0};
  localparam cas_t CAS_LT = '{agb: 1'b0, alb: 1'b1, aeb: 1'b0};

  // An unequal nibble overrides the running state; equal nibbles pass it through.
  function automatic cas_t cas_update(input cas_t cur, input logic gt, input logic lt);
    cas_t nxt;
    nxt = cur;
    if (gt) begin
      nxt = CAS_GT;
    end else if (lt) begin
      nxt = CAS_LT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_mag_cmp_nibble_cmp.sv
// Combinational 4-bit magnitude compare; shared across all steps of a compare.
module seq_mag_cmp_nibble_cmp
  import seq_mag_cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  output logic                gt_c,
  output logic                lt_c
);

  assign gt_c = (a_i > b_i);
  assign lt_c = (a_i < b_i);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator, one nibble per clock, driving a 4-bit cascade.
// SEQ_MAG_CMP_EARLY_EXIT_EN: process MSB nibble first and finish at the first unequal nibble.
module seq_mag_cmp
  import seq_mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cas_agb,
  input  logic             cas_alb,
  input  logic             cas_aeb,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cas_t               cas_q, cas_d;
  cas_t               res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b;
  logic                nib_gt_c, nib_lt_c;
  logic                last_step;

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
  assign nib_a = sa_q[WIDTH-1 -: NIBBLE_W];
  assign nib_b = sb_q[WIDTH-1 -: NIBBLE_W];
`else
  assign nib_a = sa_q[NIBBLE_W-1:0];
  assign nib_b = sb_q[NIBBLE_W-1:0];
`endif

  seq_mag_cmp_nibble_cmp u_nibble_cmp (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .gt_c (nib_gt_c),
    .lt_c (nib_lt_c)
  );

  assign last_step = (cnt_q == CNT_W'(NIBBLES - 1));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      cas_q   <= CAS_EQ;
      res_q   <= CAS_EQ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      cas_q   <= cas_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic; results only move in DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    cas_d   = cas_q;
    res_d   = res_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cas_d   = '{agb: cas_agb, alb: cas_alb, aeb: cas_aeb};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cas_d = cas_update(cas_q, nib_gt_c, nib_lt_c);
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
        sa_d = sa_q << NIBBLE_W;
        sb_d = sb_q << NIBBLE_W;
        if (last_step || nib_gt_c || nib_lt_c) begin
          state_d = DONE;
        end
`else
        sa_d = sa_q >> NIBBLE_W;
        sb_d = sb_q >> NIBBLE_W;
        if (last_step) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        res_d   = cas_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign agb  = res_q.agb;
  assign alb  = res_q.alb;
  assign aeb  = res_q.aeb;

endmodule
